cache_controller_nway: RTL and testbench
========================================

Name: cache_controller_nway

Overview:
Parametrised successor of the direct-mapped data cache controller in the MEM stage of the ARM pipeline. It provides a WAYS-way set-associative, write-through, no-write-allocate cache with true-LRU replacement. It sits between the MEM stage (address/wdata/MEM_R_EN/MEM_W_EN, ready feeding sram_freeze) and the SRAM controller, which supplies 64-bit (2-word) lines.

Parameters:
WAYS, 2, associativity; power of two, 1..8
SETS, 64, sets per way; power of two, >=2
ADDR_W, 19, significant byte-address bits; bits above are ignored

Ports:
clk  input  1  pipeline clock; all state on rising edge
rst  input  1  synchronous, active-high reset
address  input  32  byte address (already offset by 1024 upstream)
wdata  input  32  store data
MEM_R_EN  input  1  load request
MEM_W_EN  input  1  store request
rdata  output  32  load data, valid when ready=1 with MEM_R_EN
ready  output  1  request complete this cycle / idle
sram_address  output  32  address to SRAM controller
sram_wdata  output  32  store data to SRAM controller
write  output  1  SRAM write request, held until sram_ready
read  output  1  SRAM line-read request, held until sram_ready
sram_rdata  input  64  fetched line; [31:0]=word 0, [63:32]=word 1
sram_ready  input  1  SRAM controller transaction done (1-cycle pulse)

Behaviour:
- Reset: clk and rst as named; reset is synchronous and active-high. All valid bits cleared, LRU age of way i = i in every set, state=IDLE; outputs read=0, write=0, rdata=0, ready=1, sram_address=0, sram_wdata=0.
- Address split: offset bit [2] selects word in line; bits [1:0] ignored; index = [2+log2(SETS):3]; tag = [ADDR_W-1:3+log2(SETS)].
- Storage per way/set: valid, tag, 64-bit line, age of log2(WAYS) bits (none when WAYS=1).
- Hit = any way with valid and matching tag in the indexed set; at most one way hits by construction.
- States: IDLE, RD_MISS, WR_THRU.
- IDLE, neither enable: ready=1, no SRAM activity.
- IDLE, MEM_R_EN hit: ready=1 combinationally, same cycle; rdata = hit word; LRU updated at the edge; stays IDLE. 0-cycle added latency.
- IDLE, MEM_R_EN miss: ready=0; go RD_MISS.
- RD_MISS: read=1, sram_address = {address[31:3],3'b000}. On sram_ready: ready=1; rdata = selected word of sram_rdata (bypass, same cycle). At the edge, write the victim with valid=1, new tag and line, update LRU, return to IDLE.
- Victim selection: lowest-numbered invalid way, else the way with age = WAYS-1.
- LRU update on access to way w with age a: every way with age < a increments, way w gets 0. Ages always remain a permutation of 0..WAYS-1.
- IDLE, MEM_W_EN: ready=0; go WR_THRU.
- WR_THRU: write=1, sram_address = {address[31:2],2'b00}, sram_wdata = wdata. On sram_ready: ready=1. At the edge, if hit, overwrite the addressed word in the hit way and update LRU; if miss, no allocation and no LRU change. Return to IDLE.
- MEM_R_EN and MEM_W_EN both high: treated as a store.
- Request and address must stay stable while ready=0; the controller samples them every cycle and does not latch them.
- read and write are never high together; neither is asserted in IDLE.
- Reset during RD_MISS/WR_THRU: aborts the transaction, drops read/write in the following cycle, and invalidates all lines. A late sram_ready after reset is ignored in IDLE.

Optional Feature:
CACHE_STATS_EN: when defined, adds output ports hit_count [31:0] and miss_count [31:0]. Each load increments exactly one of them, once, when its ready=1 cycle completes; counts wrap at 2^32 and are cleared by rst. Stores are not counted. When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold load at 0x0000_0010 (WAYS=2): read=1 with sram_address=0x10 until sram_ready returns 64'h2222_2222_1111_1111 -> rdata=0x1111_1111, ready=1; repeat load -> hit, ready=1 same cycle, read stays 0.
- WAYS=2, SETS=64: load A=0x000, B=0x200, then reload A, then load C=0x400 (same set) -> B evicted; A hits, B misses.
- Store 0xDEAD_BEEF to cached address 0x14 -> write=1, sram_wdata=0xDEAD_BEEF, sram_address=0x14; after sram_ready, load 0x14 hits with 0xDEAD_BEEF.
- Store to uncached address 0x808, then load 0x808 -> store does no allocation; the load misses and read is asserted.
- Assert rst for one cycle mid RD_MISS, then pulse sram_ready -> read=0 after reset, no fill, next load of that address misses.
- MEM_R_EN=MEM_W_EN=1 -> write asserted, read stays 0; with CACHE_STATS_EN, after 1 miss + 3 hits on loads, miss_count=1 and hit_count=3.

Source files
------------

// File: rtl/cache_controller_nway.sv
// WAYS-way set-associative write-through, no-write-allocate data cache with true-LRU; `CACHE_STATS_EN adds hit/miss counters.
// Load hits complete in the same cycle. Misses and stores hold ready low until the SRAM controller pulses sram_ready.
module cache_controller_nway #(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int ADDR_W = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        write,
    output logic        read,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W = ADDR_W - 3 - IDX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t state_q, state_d;

    logic             valid_q [WAYS][SETS];
    logic             valid_d [WAYS][SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [TAG_W-1:0] tag_d   [WAYS][SETS];
    logic [63:0]      line_q  [WAYS][SETS];
    logic [63:0]      line_d  [WAYS][SETS];
    logic [AGE_W-1:0] age_q   [WAYS][SETS];
    logic [AGE_W-1:0] age_d   [WAYS][SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             word_sel;
    logic             hit;
    logic [AGE_W-1:0] hit_way;
    logic [AGE_W-1:0] victim;
    logic             free_found;
    logic [63:0]      hit_line;
    logic [31:0]      hit_word;
    logic             touch_en;
    logic [AGE_W-1:0] touch_way;
    logic             unused_addr_lsb;

    assign idx             = address[2+IDX_W:3];
    assign tag             = address[ADDR_W-1:3+IDX_W];
    assign word_sel        = address[2];
    assign unused_addr_lsb = ^address[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    assign hit_line = line_q[hit_way][idx];
    assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];

    // Fill the lowest empty way first; once the set is full, the oldest way goes.
    always_comb begin
        free_found = 1'b0;
        victim     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!free_found && !valid_q[w][idx]) begin
                free_found = 1'b1;
                victim     = AGE_W'(w);
            end
        end
        if (!free_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[w][idx] == AGE_W'(WAYS - 1)) begin
                    victim = AGE_W'(w);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        line_d       = line_q;
        age_d        = age_q;
        ready        = 1'b1;
        rdata        = '0;
        read         = 1'b0;
        write        = 1'b0;
        sram_address = '0;
        sram_wdata   = '0;
        touch_en     = 1'b0;
        touch_way    = hit_way;

        case (state_q)
            IDLE: begin
                // A simultaneous load+store request is serviced as a store.
                if (MEM_W_EN) begin
                    ready   = 1'b0;
                    state_d = WR_THRU;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        rdata    = hit_word;
                        touch_en = 1'b1;
                    end else begin
                        ready   = 1'b0;
                        state_d = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                read         = 1'b1;
                ready        = 1'b0;
                sram_address = {address[31:3], 3'b000};
                if (sram_ready) begin
                    ready                 = 1'b1;
                    rdata                 = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                    valid_d[victim][idx]  = 1'b1;
                    tag_d[victim][idx]    = tag;
                    line_d[victim][idx]   = sram_rdata;
                    touch_en              = 1'b1;
                    touch_way             = victim;
                    state_d               = IDLE;
                end
            end
            WR_THRU: begin
                write        = 1'b1;
                ready        = 1'b0;
                sram_address = {address[31:2], 2'b00};
                sram_wdata   = wdata;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                    if (hit) begin
                        if (word_sel) line_d[hit_way][idx][63:32] = wdata;
                        else          line_d[hit_way][idx][31:0]  = wdata;
                        touch_en = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Ages stay a permutation: everything younger than the touched way ages by one.
        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[w][idx] < age_q[touch_way][idx]) begin
                    age_d[w][idx] = age_q[w][idx] + AGE_W'(1);
                end
            end
            age_d[touch_way][idx] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    age_q[w][s]   <= AGE_W'(w);
                end
            end
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    // Tags and data are only meaningful behind a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if ((state_q == IDLE) && MEM_R_EN && !MEM_W_EN && hit) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if ((state_q == RD_MISS) && sram_ready) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller_nway.sv
// Bench for cache_controller_nway: directed vector table, reset-abort sequence, randomized traffic vs an LRU-queue model.
module tb_cache_controller_nway;

    localparam int WAYS   = 2;
    localparam int SETS   = 64;
    localparam int ADDR_W = 19;
    localparam int IDX_W  = $clog2(SETS);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
    logic        MEM_R_EN, MEM_W_EN, ready, write, read, sram_ready;
    logic [63:0] sram_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_controller_nway #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .write(write), .read(read),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_hit_cnt = 0;
    int exp_miss_cnt = 0;

    logic [31:0] mem [int];
    int          set_q [SETS][$];

    bit          o_rd, o_wr, o_done, o_excl;
    int          o_cyc;
    logic [31:0] o_got, o_addr, o_wd;

    typedef struct {
        int          op;       // 0 load, 1 store, 2 load+store
        logic [31:0] a;
        logic [31:0] wd;
        bit          exp_miss;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int wkey(input logic [31:0] a);
        return int'(a[ADDR_W-1:2]);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        w = 32'(a[ADDR_W-1:2]);
        if (mem.exists(wkey(a))) return mem[wkey(a)];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Each set is a recency list of tags, most recent first.
    task automatic model_access(input logic [31:0] a, input bit is_load, output bit hit);
        int s, t, pos;
        s   = int'(a[2+IDX_W:3]);
        t   = int'(a[ADDR_W-1:3+IDX_W]);
        pos = -1;
        for (int i = 0; i < set_q[s].size(); i++) if (set_q[s][i] == t) pos = i;
        hit = (pos >= 0);
        if (hit) begin
            set_q[s].delete(pos);
            set_q[s].push_front(t);
        end else if (is_load) begin
            if (set_q[s].size() == WAYS) void'(set_q[s].pop_back());
            set_q[s].push_front(t);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) set_q[s].delete();
        exp_hit_cnt  = 0;
        exp_miss_cnt = 0;
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic access(input int op, input logic [31:0] a, input logic [31:0] wd, input int lat);
        int wc;
        wc = 0;
        o_rd = 0; o_wr = 0; o_done = 0; o_excl = 0; o_cyc = 0;
        o_got = '0; o_addr = '0; o_wd = '0;
        MEM_R_EN = (op != 1);
        MEM_W_EN = (op != 0);
        address  = a;
        wdata    = wd;
        while (!o_done && o_cyc < 64) begin
            @(negedge clk);
            if (read && write) o_excl = 1;
            o_rd |= read;
            o_wr |= write;
            if (!ready && (read || write)) begin
                if (wc == lat) begin
                    o_addr     = sram_address;
                    o_wd       = sram_wdata;
                    sram_rdata = {mem_rd({a[31:3], 3'b100}), mem_rd({a[31:3], 3'b000})};
                    if (op != 0) mem[wkey(a)] = wd;
                    sram_ready = 1'b1;
                    #1;
                end else begin
                    wc++;
                end
            end
            if (ready) begin
                o_done = 1;
                o_got  = rdata;
            end
            @(posedge clk);
            #1;
            sram_ready = 1'b0;
            o_cyc++;
        end
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    task automatic judge(input string nm, input int op, input logic [31:0] a, input logic [31:0] wd,
                         input bit exp_miss, input logic [31:0] exp_d);
        chk({nm, " completes"}, 32'(o_done), 32'd1);
        chk({nm, " rd/wr overlap"}, 32'(o_excl), 32'd0);
        if (op == 0) begin
            chk({nm, " read asserted"}, 32'(o_rd), 32'(exp_miss));
            chk({nm, " write asserted"}, 32'(o_wr), 32'd0);
            chk({nm, " rdata"}, o_got, exp_d);
            if (exp_miss) chk({nm, " fill addr"}, o_addr, {a[31:3], 3'b000});
            else          chk({nm, " hit cycles"}, 32'(o_cyc), 32'd1);
            if (exp_miss) exp_miss_cnt++;
            else          exp_hit_cnt++;
        end else begin
            chk({nm, " write asserted"}, 32'(o_wr), 32'd1);
            chk({nm, " read asserted"}, 32'(o_rd), 32'd0);
            chk({nm, " store addr"}, o_addr, {a[31:2], 2'b00});
            chk({nm, " store data"}, o_wd, wd);
        end
    endtask

    task automatic run_model(input int op, input logic [31:0] a, input logic [31:0] wd, input int lat,
                             input string nm);
        bit          exp_hit;
        logic [31:0] exp_d;
        exp_d = mem_rd(a);
        model_access(a, op == 0, exp_hit);
        access(op, a, wd, lat);
        judge(nm, op, a, wd, !exp_hit, exp_d);
    endtask

    task automatic chk_stats(input string nm);
`ifdef CACHE_STATS_EN
        chk({nm, " hit_count"}, hit_count, 32'(exp_hit_cnt));
        chk({nm, " miss_count"}, miss_count, 32'(exp_miss_cnt));
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{0, 32'h0000_0010, 32'h0,         1'b1, 32'h1111_1111};
        tbl[1]  = '{0, 32'h0000_0010, 32'h0,         1'b0, 32'h1111_1111};
        tbl[2]  = '{0, 32'h0000_0014, 32'h0,         1'b0, 32'h2222_2222};
        tbl[3]  = '{0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_AAAA};
        tbl[4]  = '{0, 32'h0000_0200, 32'h0,         1'b1, 32'h0000_BBBB};
        tbl[5]  = '{0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_AAAA};
        tbl[6]  = '{0, 32'h0000_0400, 32'h0,         1'b1, 32'h0000_CCCC};
        tbl[7]  = '{0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_AAAA};
        tbl[8]  = '{0, 32'h0000_0200, 32'h0,         1'b1, 32'h0000_BBBB};
        tbl[9]  = '{1, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[10] = '{0, 32'h0000_0014, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[11] = '{1, 32'h0000_0808, 32'h0000_1234, 1'b0, 32'h0};
        tbl[12] = '{0, 32'h0000_0808, 32'h0,         1'b1, 32'h0000_1234};
        tbl[13] = '{2, 32'h0000_0010, 32'hCAFE_0001, 1'b0, 32'h0};
        tbl[14] = '{0, 32'h0000_0010, 32'h0,         1'b0, 32'hCAFE_0001};
        mem[wkey(32'h10)]  = 32'h1111_1111;
        mem[wkey(32'h14)]  = 32'h2222_2222;
        mem[wkey(32'h000)] = 32'h0000_AAAA;
        mem[wkey(32'h200)] = 32'h0000_BBBB;
        mem[wkey(32'h400)] = 32'h0000_CCCC;

        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; wdata = '0;
        sram_ready = 1'b0; sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset read", 32'(read), 32'd0);
        chk("reset write", 32'(write), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset sram_address", sram_address, 32'd0);
        chk("reset sram_wdata", sram_wdata, 32'd0);
        chk_stats("reset");
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            access(tbl[i].op, tbl[i].a, tbl[i].wd, i % 3);
            judge($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].exp_miss, tbl[i].exp_rd);
        end
        chk_stats("table");

        // Reset in the middle of a line fill, followed by a stale sram_ready.
        address  = 32'h0000_0030;
        MEM_R_EN = 1'b1;
        @(negedge clk);
        chk("rstmid ready low", 32'(ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid read up", 32'(read), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; MEM_R_EN = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid read dropped", 32'(read), 32'd0);
        sram_rdata = 64'h3333_3333_4444_4444;
        sram_ready = 1'b1;
        #1;
        chk("rstmid stale ready", 32'(ready), 32'd1);
        chk("rstmid stale write", 32'(write), 32'd0);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        @(negedge clk);
        chk("rstmid idle read", 32'(read), 32'd0);
        @(posedge clk); #1;
        model_clear();
        chk_stats("rstmid");
        run_model(0, 32'h0000_0030, 32'h0, 1, "rstmid reload");
        run_model(0, 32'h0000_0010, 32'h0, 0, "rstmid invalidated");

        for (int i = 0; i < 400; i++) begin
            int          r, op;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            op = (r < 6) ? 0 : ((r < 9) ? 1 : 2);
            a  = ($urandom_range(0, 3) << (3 + IDX_W)) | ($urandom_range(0, 3) << 3) |
                 ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
            run_model(op, a, $urandom, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end
        chk_stats("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
